// File: rtl/moddiv_pkg.sv
// Shared definitions for the modular-division operand load front end:
// controller state encoding and operand geometry constants.
package moddiv_pkg;

  localparam int OP_W      = 256;
  localparam int WORD_W    = 16;
  localparam int NWORDS    = 16;
  localparam int SHCNT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STRIP = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/moddiv_opload_ctrl.sv
// Operand load controller for the 256-bit shift register of the modular
// divider. Streams 16 words into the register (LSW first) and optionally
// strips trailing zeros with 1-bit right shifts, reporting how many shifts
// were made and whether the operand turned out to be zero.
module moddiv_opload_ctrl #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              strip_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              reg_lsb,
  output logic [WORD_W-1:0] regin,
  output logic              we,
  output logic              sel_rs,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  shift_cnt,
  output logic              zero_flag
);

  import moddiv_pkg::*;

  localparam int WCNT_W = $clog2(NWORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SHCNT_MAX);

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wordCnt;
  logic [CNT_W-1:0]    r_shiftCnt;
  logic                r_zeroFlag;
  logic                r_stripQ;
  logic                r_done;
  logic                r_busy;
  logic                r_inReady;
  logic                r_selRs;

  logic                w_accept;
  logic                w_shiftMore;
  logic                w_we;

  // A word is taken whenever the stream offers one while we are loading;
  // a strip shift happens while the LSB is still zero and the cap is not hit.
  always_comb begin
    w_accept    = 1'b0;
    w_shiftMore = 1'b0;
    w_we        = 1'b0;
    if (r_state == LOAD) begin
      w_accept = in_valid;
      w_we     = in_valid;
    end else if (r_state == STRIP) begin
      w_shiftMore = !reg_lsb && (r_shiftCnt != CNT_LAST);
      w_we        = w_shiftMore;
    end
  end

  // Controller FSM with its counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wordCnt  <= '0;
      r_shiftCnt <= '0;
      r_zeroFlag <= 1'b0;
      r_stripQ   <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_inReady  <= 1'b0;
      r_selRs    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_stripQ   <= strip_en;
            r_shiftCnt <= '0;
            r_zeroFlag <= 1'b0;
            r_wordCnt  <= '0;
            r_state    <= LOAD;
            r_busy     <= 1'b1;
            r_inReady  <= 1'b1;
            r_selRs    <= 1'b0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_wordCnt <= r_wordCnt + 1'b1;
            if (r_wordCnt == LAST_WORD) begin
              r_inReady <= 1'b0;
              if (r_stripQ) begin
                r_state <= STRIP;
                r_selRs <= 1'b1;
              end else begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        STRIP: begin
          if (w_shiftMore) begin
            r_shiftCnt <= r_shiftCnt + 1'b1;
          end else begin
            // After the full shift budget, a zero LSB means nothing was ever set.
            if (!reg_lsb) begin
              r_zeroFlag <= 1'b1;
            end
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_selRs <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign regin     = in_data;
  assign we        = w_we;
  assign sel_rs    = r_selRs;
  assign busy      = r_busy;
  assign done      = r_done;
  assign shift_cnt = r_shiftCnt;
  assign zero_flag = r_zeroFlag;

endmodule

// File: tb/tb_moddiv_opload_ctrl.sv
// Bench for the operand load controller, paired with a behavioural model of
// the 256-bit shift register so the final register contents can be checked.
module tb_moddiv_opload_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         strip_en = 1'b0;
  logic         in_valid = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_ready;
  logic         reg_lsb;
  logic [15:0]  regin;
  logic         we;
  logic         sel_rs;
  logic         busy;
  logic         done;
  logic [7:0]   shift_cnt;
  logic         zero_flag;
  logic [255:0] shreg = '0;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  moddiv_opload_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .strip_en(strip_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .reg_lsb(reg_lsb), .regin(regin), .we(we), .sel_rs(sel_rs),
    .busy(busy), .done(done), .shift_cnt(shift_cnt), .zero_flag(zero_flag)
  );

  // Shift register that the controller drives: load at the top while
  // shifting right by a word, or shift right by one bit.
  always @(posedge clk) begin
    if (we) shreg <= sel_rs ? (shreg >> 1) : {regin, shreg[255:16]};
  end
  assign reg_lsb = shreg[0];

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Number of 1-bit shifts the strip should make: trailing zero count,
  // capped at 255 (a zero operand also stops at 255).
  function automatic int expShifts(input logic [255:0] op);
    for (int i = 0; i < 255; i++) if (op[i]) return i;
    return 255;
  endfunction

  // Drives one complete operation and gathers what was observed.
  task automatic applyStimulus(input logic [255:0] op, input bit strip, input bit gaps,
                               input bit busyStarts, output int doneCyc, output int writes,
                               output int weBad, output bit busyAfter);
    int wi;
    wi = 0; doneCyc = -1; writes = 0; weBad = 0;
    @(posedge clk); #1;
    start = 1'b1; strip_en = strip; in_valid = 1'b0;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      @(posedge clk); #1;
      start = busyStarts && (cyc == 5);
      if (done) begin
        doneCyc = cyc;
        start = busyStarts;
        in_valid = 1'b1; in_data = 16'($urandom);
        #1;
        if (we) weBad++;
        break;
      end
      if (wi < 16) begin
        in_valid = !gaps || (cyc % 2 == 1);
        in_data = in_valid ? op[16*wi +: 16] : 16'($urandom);
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = 16'($urandom);
      end
      #1;
      if (we) writes++;
      if (we && !busy) weBad++;
      if (in_ready && (we !== in_valid)) weBad++;
      if (in_valid && in_ready) wi++;
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'($urandom);
    #1;
    if (we) weBad++;
    busyAfter = busy;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_ready got %b expected 0", in_ready); end
    testsRun++; if (we !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we got %b expected 0", we); end
    testsRun++; if (sel_rs !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_sel_rs got %b expected 0", sel_rs); end
    testsRun++; if (shift_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_shift_cnt got %0d expected 0", shift_cnt); end
    testsRun++; if (zero_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_zero_flag got %b expected 0", zero_flag); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_load_no_strip();
    logic [255:0] op;
    int dc, wr, bad; bit ba;
    for (int i = 0; i < 16; i++) op[16*i +: 16] = 16'(i + 1);
    applyStimulus(op, 1'b0, 1'b0, 1'b0, dc, wr, bad, ba);
    testsRun++; if (dc != 17) begin testsFailed++; $display("[TB] FAIL load_done_cycle got %0d expected 17", dc); end
    testsRun++; if (wr != 16) begin testsFailed++; $display("[TB] FAIL load_writes got %0d expected 16", wr); end
    testsRun++; if (shreg !== op) begin testsFailed++; $display("[TB] FAIL load_register got %h expected %h", shreg, op); end
    testsRun++; if (shift_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL load_shift_cnt got %0d expected 0", shift_cnt); end
    testsRun++; if (bad != 0) begin testsFailed++; $display("[TB] FAIL load_we_misuse got %0d expected 0", bad); end
  endtask

  task automatic test_strip_five();
    logic [255:0] op;
    int dc, wr, bad; bit ba;
    op = 256'h60;
    applyStimulus(op, 1'b1, 1'b0, 1'b0, dc, wr, bad, ba);
    testsRun++; if (dc != 23) begin testsFailed++; $display("[TB] FAIL strip5_done_cycle got %0d expected 23", dc); end
    testsRun++; if (shift_cnt !== 8'd5) begin testsFailed++; $display("[TB] FAIL strip5_shift_cnt got %0d expected 5", shift_cnt); end
    testsRun++; if (shreg !== 256'h3) begin testsFailed++; $display("[TB] FAIL strip5_register got %h expected 3", shreg); end
    testsRun++; if (zero_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL strip5_zero_flag got %b expected 0", zero_flag); end
    testsRun++; if (wr != 21 || bad != 0) begin testsFailed++; $display("[TB] FAIL strip5_writes got %0d/%0d expected 21/0", wr, bad); end
  endtask

  task automatic test_boundary_operands();
    logic [255:0] op;
    int dc, wr, bad; bit ba;
    op = '0;
    applyStimulus(op, 1'b1, 1'b0, 1'b0, dc, wr, bad, ba);
    testsRun++; if (dc != 273) begin testsFailed++; $display("[TB] FAIL zero_done_cycle got %0d expected 273", dc); end
    testsRun++; if (shift_cnt !== 8'd255) begin testsFailed++; $display("[TB] FAIL zero_shift_cnt got %0d expected 255", shift_cnt); end
    testsRun++; if (zero_flag !== 1'b1) begin testsFailed++; $display("[TB] FAIL zero_zero_flag got %b expected 1", zero_flag); end
    op = '0; op[255] = 1'b1;
    applyStimulus(op, 1'b1, 1'b0, 1'b0, dc, wr, bad, ba);
    testsRun++; if (dc != 273) begin testsFailed++; $display("[TB] FAIL topbit_done_cycle got %0d expected 273", dc); end
    testsRun++; if (shift_cnt !== 8'd255) begin testsFailed++; $display("[TB] FAIL topbit_shift_cnt got %0d expected 255", shift_cnt); end
    testsRun++; if (zero_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL topbit_zero_flag got %b expected 0", zero_flag); end
    testsRun++; if (shreg !== 256'h1) begin testsFailed++; $display("[TB] FAIL topbit_register got %h expected 1", shreg); end
  endtask

  task automatic test_valid_gaps();
    logic [255:0] op;
    int dc, wr, bad; bit ba;
    op = rand256();
    applyStimulus(op, 1'b0, 1'b1, 1'b0, dc, wr, bad, ba);
    testsRun++; if (dc != 32) begin testsFailed++; $display("[TB] FAIL gaps_done_cycle got %0d expected 32", dc); end
    testsRun++; if (wr != 16 || bad != 0) begin testsFailed++; $display("[TB] FAIL gaps_writes got %0d/%0d expected 16/0", wr, bad); end
    testsRun++; if (shreg !== op) begin testsFailed++; $display("[TB] FAIL gaps_register got %h expected %h", shreg, op); end
  endtask

  task automatic test_random_ops();
    logic [255:0] op, expReg;
    int dc, wr, bad, k, expDone; bit ba, s, g;
    for (int n = 0; n < 8; n++) begin
      op = (rand256() | 256'd1) << $urandom_range(0, 60);
      s = 1'($urandom_range(0, 1));
      g = 1'($urandom_range(0, 1));
      k = s ? expShifts(op) : 0;
      expReg = op >> k;
      expDone = s ? (g ? 31 : 16) + 2 + k : (g ? 31 : 16) + 1;
      applyStimulus(op, s, g, 1'b0, dc, wr, bad, ba);
      testsRun++; if (dc != expDone) begin testsFailed++; $display("[TB] FAIL rand%0d_done_cycle got %0d expected %0d", n, dc, expDone); end
      testsRun++; if (shift_cnt !== 8'(k)) begin testsFailed++; $display("[TB] FAIL rand%0d_shift_cnt got %0d expected %0d", n, shift_cnt, k); end
      testsRun++; if (shreg !== expReg) begin testsFailed++; $display("[TB] FAIL rand%0d_register got %h expected %h", n, shreg, expReg); end
      testsRun++; if (wr != 16 + k || bad != 0) begin testsFailed++; $display("[TB] FAIL rand%0d_writes got %0d/%0d expected %0d/0", n, wr, bad, 16 + k); end
      testsRun++; if (zero_flag !== 1'b0) begin testsFailed++; $display("[TB] FAIL rand%0d_zero_flag got %b expected 0", n, zero_flag); end
    end
  endtask

  task automatic test_reset_mid_strip();
    logic [255:0] op;
    int dc, wr, bad, donePulses; bit ba;
    op = 256'd1 << 20;
    @(posedge clk); #1;
    start = 1'b1; strip_en = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = (cyc <= 16);
      in_data = (cyc <= 16) ? op[16*(cyc-1) +: 16] : 16'h0;
    end
    testsRun++; if (shift_cnt !== 8'd3 || sel_rs !== 1'b1) begin testsFailed++; $display("[TB] FAIL midstrip_progress got cnt=%0d sel=%b expected 3/1", shift_cnt, sel_rs); end
    rst = 1'b1;
    @(posedge clk); #1;
    testsRun++; if ({busy, done, in_ready, sel_rs, zero_flag} !== 5'b0 || shift_cnt !== 8'd0)
      begin testsFailed++; $display("[TB] FAIL midstrip_reset got busy=%b done=%b rdy=%b sel=%b zf=%b cnt=%0d expected all 0", busy, done, in_ready, sel_rs, zero_flag, shift_cnt); end
    testsRun++; if (we !== 1'b0) begin testsFailed++; $display("[TB] FAIL midstrip_reset_we got %b expected 0", we); end
    rst = 1'b0;
    donePulses = 0;
    repeat (30) begin @(posedge clk); #1; if (done || busy) donePulses++; end
    testsRun++; if (donePulses != 0) begin testsFailed++; $display("[TB] FAIL midstrip_no_done got %0d expected 0", donePulses); end
    op = 256'h0123_4567_89AB_CDEF << 7;
    applyStimulus(op, 1'b1, 1'b0, 1'b0, dc, wr, bad, ba);
    testsRun++; if (dc != 25 || shift_cnt !== 8'd7) begin testsFailed++; $display("[TB] FAIL after_reset_op got done=%0d cnt=%0d expected 25/7", dc, shift_cnt); end
    testsRun++; if (shreg !== (op >> 7)) begin testsFailed++; $display("[TB] FAIL after_reset_register got %h expected %h", shreg, op >> 7); end
  endtask

  task automatic test_start_while_busy();
    logic [255:0] op;
    int dc, wr, bad; bit ba;
    op = rand256();
    applyStimulus(op, 1'b0, 1'b0, 1'b1, dc, wr, bad, ba);
    testsRun++; if (dc != 17) begin testsFailed++; $display("[TB] FAIL busystart_done_cycle got %0d expected 17", dc); end
    testsRun++; if (wr != 16 || bad != 0) begin testsFailed++; $display("[TB] FAIL busystart_writes got %0d/%0d expected 16/0", wr, bad); end
    testsRun++; if (shreg !== op) begin testsFailed++; $display("[TB] FAIL busystart_register got %h expected %h", shreg, op); end
    testsRun++; if (ba !== 1'b0) begin testsFailed++; $display("[TB] FAIL busystart_restart got busy=%b expected 0", ba); end
  endtask

  initial begin
    test_reset();
    test_load_no_strip();
    test_strip_five();
    test_boundary_operands();
    test_valid_gaps();
    test_random_ops();
    test_reset_mid_strip();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
